// File: rtl/mem_arbiter_if.sv
// Request, response and memory-side bundle for the two-port memory arbiter.
// The slave modport is the arbiter; the master modport is the requester and memory environment.
interface mem_arbiter_if;
  logic        Req0;
  logic        Write0;
  logic [9:0]  Addr0;
  logic [31:0] WData0;
  logic        Gnt0;
  logic        RValid0;
  logic [31:0] RData0;
  logic        Stall0;

  logic        Req1;
  logic        Write1;
  logic [9:0]  Addr1;
  logic [31:0] WData1;
  logic        Gnt1;
  logic        RValid1;
  logic [31:0] RData1;
  logic        Stall1;
  logic        Lock1;

  logic [9:0]  MemAddr;
  logic [31:0] MemWData;
  logic        MemWE;
  logic [31:0] MemRData;
  logic        Busy;

  modport slave (
    input  Req0, Write0, Addr0, WData0,
    input  Req1, Write1, Addr1, WData1, Lock1,
    input  MemRData,
    output Gnt0, RValid0, RData0, Stall0,
    output Gnt1, RValid1, RData1, Stall1,
    output MemAddr, MemWData, MemWE, Busy
  );

  modport master (
    output Req0, Write0, Addr0, WData0,
    output Req1, Write1, Addr1, WData1, Lock1,
    output MemRData,
    input  Gnt0, RValid0, RData0, Stall0,
    input  Gnt1, RValid1, RData1, Stall1,
    input  MemAddr, MemWData, MemWE, Busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port memory, one access per two cycles.
// Define MEM_ARB_LOCK_EN to let port 1 hold ownership across accesses via Lock1.
module mem_arbiter (
  input  logic          Clock,
  input  logic          Reset_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic        last_gnt_reg, last_gnt_next;
  logic        win_reg, win_next;
  logic        write_reg, write_next;
  logic [9:0]  addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;

  logic [1:0]  req;
  logic [1:0]  wr;
  logic [9:0]  addr  [2];
  logic [31:0] wdata [2];
  logic [1:0]  elig;
  logic        winner;
  logic        lock_eff;
  logic [1:0]  gnt;
  logic        busy;
  logic        mem_we;
  logic        capture;

  assign req      = {bus.Req1, bus.Req0};
  assign wr       = {bus.Write1, bus.Write0};
  assign addr[0]  = bus.Addr0;
  assign addr[1]  = bus.Addr1;
  assign wdata[0] = bus.WData0;
  assign wdata[1] = bus.WData1;

`ifdef MEM_ARB_LOCK_EN
  logic lock_reg, lock_next;

  // Dropping Lock1 in IDLE releases the lock for the arbitration of that same cycle.
  assign lock_eff = lock_reg & bus.Lock1;

  always_comb begin
    lock_next = lock_reg;
    if (state_reg == IDLE && !bus.Lock1)
      lock_next = 1'b0;
    else if (state_reg == ACCESS && win_reg && bus.Lock1)
      lock_next = 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n)
      lock_reg <= 1'b0;
    else
      lock_reg <= lock_next;
  end
`else
  logic lock_unused;

  assign lock_unused = bus.Lock1;
  assign lock_eff    = 1'b0;
`endif

  assign elig = {req[1], req[0] & ~lock_eff};

  always_comb begin
    if (&elig)
      winner = ~last_gnt_reg;
    else
      winner = elig[1];
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_reg    <= IDLE;
      last_gnt_reg <= 1'b1;
      win_reg      <= 1'b0;
      write_reg    <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      last_gnt_reg <= last_gnt_next;
      win_reg      <= win_next;
      write_reg    <= write_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    last_gnt_next = last_gnt_reg;
    win_next      = win_reg;
    write_next    = write_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (|elig) begin
          state_next    = ACCESS;
          win_next      = winner;
          write_next    = wr[winner];
          addr_next     = addr[winner];
          wdata_next    = wdata[winner];
          last_gnt_next = winner;
        end
      end
      ACCESS:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reset_n gates the write strobe so a reset landing in ACCESS cannot corrupt memory.
  always_comb begin
    gnt    = '0;
    busy   = 1'b0;
    mem_we = 1'b0;
    if (state_reg == ACCESS) begin
      busy         = 1'b1;
      gnt[win_reg] = 1'b1;
      mem_we       = write_reg & Reset_n;
    end
  end

  assign capture = (state_reg == ACCESS) & ~write_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : port_g
      logic        rvalid_reg;
      logic [31:0] rdata_reg;
      logic        stall;

      assign stall = req[gi] & ~gnt[gi];

      always_ff @(posedge Clock) begin
        if (!Reset_n) begin
          rvalid_reg <= 1'b0;
          rdata_reg  <= '0;
        end else begin
          rvalid_reg <= capture & (win_reg == 1'(gi));
          if (capture && win_reg == 1'(gi))
            rdata_reg <= bus.MemRData;
        end
      end
    end
  endgenerate

  assign bus.Gnt0     = gnt[0];
  assign bus.Gnt1     = gnt[1];
  assign bus.Stall0   = port_g[0].stall;
  assign bus.Stall1   = port_g[1].stall;
  assign bus.RValid0  = port_g[0].rvalid_reg;
  assign bus.RValid1  = port_g[1].rvalid_reg;
  assign bus.RData0   = port_g[0].rdata_reg;
  assign bus.RData1   = port_g[1].rdata_reg;
  assign bus.MemAddr  = addr_reg;
  assign bus.MemWData = wdata_reg;
  assign bus.MemWE    = mem_we;
  assign bus.Busy     = busy;

endmodule
